// File: rtl/reg_dump_unit.sv
// reg_dump_unit: streams a contiguous window of a register file out over a
// valid/ready port. It reads one register through the test port, presents
// it, then moves to the next address. Addresses wrap modulo 2**ADDR_W.
//
// Handshake: a word transfers on a rising edge where dumpValid and dumpReady
// are both 1. While dumpValid is high and dumpReady is low, dumpData,
// dumpAddr and dumpLast are held unchanged. dumpValid never drops without a
// transfer, except on reset.
//
// Optional feature: define DUMP_CHECKSUM_EN to append one checksum word.
// That word carries the XOR of every register word sent, has dumpAddr=0,
// and is the only word of the dump with dumpLast set.
module reg_dump_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] addressTest,
  input  logic [DATA_W-1:0] outputTest,
  output logic              dumpValid,
  input  logic              dumpReady,
  output logic [DATA_W-1:0] dumpData,
  output logic [ADDR_W-1:0] dumpAddr,
  output logic              dumpLast,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbgState
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
`ifdef DUMP_CHECKSUM_EN
    SUM  = 3'd3,
`endif
    DONE = 3'd4
  } state_t;

  // A count of 0 selects the whole register file.
  localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_LEFT   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            nextState;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic              handshake;
  logic              lastWord;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] xorAcc;
`endif

  assign handshake = dumpValid && dumpReady;
  assign lastWord  = (remaining == ONE_LEFT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = READ;
      READ: nextState = SEND;
      SEND: begin
        if (handshake) begin
          if (!lastWord) nextState = READ;
`ifdef DUMP_CHECKSUM_EN
          else           nextState = SUM;
`else
          else           nextState = DONE;
`endif
        end
      end
`ifdef DUMP_CHECKSUM_EN
      SUM:  if (handshake) nextState = DONE;
`endif
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Status outputs, decoded from the state alone.
  always_comb begin
    dumpValid = (state == SEND);
`ifdef DUMP_CHECKSUM_EN
    if (state == SUM) dumpValid = 1'b1;
`endif
    busy     = (state != IDLE);
    done     = (state == DONE);
    dbgState = state;
  end

  // Datapath: address pointer, word counter, output word and checksum.
  // addressTest is loaded one cycle early, so it equals ptr throughout READ
  // and keeps its value in every other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      remaining   <= '0;
      addressTest <= '0;
      dumpData    <= '0;
      dumpAddr    <= '0;
      dumpLast    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      xorAcc      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr         <= startAddr;
            addressTest <= startAddr;
            remaining   <= (count == '0) ? FULL_COUNT : count;
`ifdef DUMP_CHECKSUM_EN
            xorAcc      <= '0;
`endif
          end
        end
        READ: begin
          dumpData <= outputTest;
          dumpAddr <= ptr;
`ifdef DUMP_CHECKSUM_EN
          dumpLast <= 1'b0;
`else
          dumpLast <= lastWord;
`endif
        end
        SEND: begin
          if (handshake) begin
`ifdef DUMP_CHECKSUM_EN
            xorAcc <= xorAcc ^ dumpData;
`endif
            if (!lastWord) begin
              remaining   <= remaining - ONE_LEFT;
              ptr         <= ptr + ADDR_ONE;
              addressTest <= ptr + ADDR_ONE;
            end
`ifdef DUMP_CHECKSUM_EN
            else begin
              // Build the checksum word in place of the final register word.
              dumpData <= xorAcc ^ dumpData;
              dumpAddr <= '0;
              dumpLast <= 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
